// File: rtl/execute.sv
// bexkat1 execute stage: ALU, address/branch-target generation, condition codes,
// and a one-bit-per-cycle multiply/divide unit. All memory-stage inputs are registered here.
package bexkat1Def;
  localparam logic [3:0] T_INH    = 4'h0;
  localparam logic [3:0] T_PUSH   = 4'h1;
  localparam logic [3:0] T_POP    = 4'h2;
  localparam logic [3:0] T_MD     = 4'h6;
  localparam logic [3:0] T_ALU    = 4'h9;
  localparam logic [3:0] T_LOAD   = 4'hb;
  localparam logic [3:0] T_STORE  = 4'hc;
  localparam logic [3:0] T_BRANCH = 4'hd;
endpackage

module execute (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] reg_data1_i,
  input  logic [31:0] reg_data2_i,
  input  logic [31:0] sp_data_i,
  input  logic [1:0]  sp_write_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] reg_data1_o,
  output logic [31:0] reg_data2_o,
  output logic [31:0] sp_data_o,
  output logic [1:0]  sp_write_o,
  output logic [31:0] result_o,
  output logic        pc_set_o,
  output logic [3:0]  ccr_o
);
  import bexkat1Def::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [4:0]  count_r;
  logic [2:0]  md_op_r;
  logic [31:0] md_a_r, md_b_r, acc_r;

  logic [63:0] ir_r;
  logic [31:0] pc_r, reg_data1_r, reg_data2_r, sp_data_r, result_r;
  logic [1:0]  sp_write_r;
  logic        pc_set_r;
  logic [3:0]  ccr_r;

  logic [3:0]  type_s, op_s;
  logic [31:0] imm_s, opa_s, opb_s;
  logic [32:0] sum_s, sub_s;
  logic [31:0] alu_res_s;
  logic        alu_c_s, alu_v_s;
  logic [31:0] result_s, md_result_s;
  logic        cond_s, taken_s;
  logic        issue_md_s, advance_s, bubble_s;
  logic [32:0] rem_shift_s;
  logic [31:0] rem_diff_s;
  logic        take_s;
  logic [31:0] md_a_next_s, md_b_next_s, acc_next_s;

  assign type_s = ir_i[31:28];
  assign op_s   = ir_i[27:24];
  assign imm_s  = ir_i[63:32];
  assign opa_s  = reg_data1_i;
  assign opb_s  = ir_i[27] ? imm_s : reg_data2_i;
  assign sum_s  = {1'b0, opa_s} + {1'b0, opb_s};
  assign sub_s  = {1'b0, opa_s} - {1'b0, opb_s};

  assign issue_md_s = (state_r == S_IDLE) && (type_s == T_MD);
  assign advance_s  = !stall_i && (((state_r == S_IDLE) && (type_s != T_MD)) || (state_r == S_DONE));
  assign bubble_s   = !stall_i && (issue_md_s || (state_r == S_BUSY));
  assign stall_o    = stall_i || (state_r == S_BUSY) || issue_md_s;

  // ALU datapath and its condition-code side effects
  always_comb begin
    alu_res_s = 32'h0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op_s[2:0])
      3'd0: begin
        alu_res_s = sum_s[31:0];
        alu_c_s   = sum_s[32];
        alu_v_s   = (opa_s[31] == opb_s[31]) && (sum_s[31] != opa_s[31]);
      end
      3'd1: begin
        alu_res_s = sub_s[31:0];
        alu_c_s   = sub_s[32];
        alu_v_s   = (opa_s[31] != opb_s[31]) && (sub_s[31] != opa_s[31]);
      end
      3'd2: alu_res_s = opa_s & opb_s;
      3'd3: alu_res_s = opa_s | opb_s;
      3'd4: alu_res_s = opa_s ^ opb_s;
      3'd5: alu_res_s = opa_s << opb_s[4:0];
      3'd6: alu_res_s = opa_s >> opb_s[4:0];
      3'd7: alu_res_s = $signed(opa_s) >>> opb_s[4:0];
      default: alu_res_s = 32'h0;
    endcase
  end

  // Branch condition, evaluated against the already-registered flags
  always_comb begin
    cond_s = 1'b0;
    case (op_s)
      4'd0: cond_s = 1'b1;
      4'd1: cond_s = ccr_r[0];
      4'd2: cond_s = !ccr_r[0];
      4'd3: cond_s = ccr_r[2] ^ ccr_r[1];
      4'd4: cond_s = ccr_r[3];
      default: cond_s = 1'b0;
    endcase
  end
  assign taken_s = (type_s == T_BRANCH) && cond_s;

  // Multiply/divide result selection from the iteration registers
  always_comb begin
    md_result_s = 32'h0;
    case (md_op_r)
      3'd0: md_result_s = acc_r;
      3'd1: md_result_s = md_a_r;
      3'd2: md_result_s = acc_r;
      default: md_result_s = 32'h0;
    endcase
  end

  // Result/address mux by instruction type
  always_comb begin
    result_s = 32'h0;
    case (type_s)
      T_ALU:           result_s = alu_res_s;
      T_LOAD, T_STORE: result_s = reg_data2_i + imm_s;
      T_PUSH, T_INH:   result_s = imm_s;
      T_POP:           result_s = reg_data1_i;
      T_BRANCH:        result_s = pc_i + imm_s;
      T_MD:            result_s = md_result_s;
      default:         result_s = 32'h0;
    endcase
  end

  // One multiply or restoring-divide step. Divide reuses md_a_r as
  // dividend-in/quotient-out and acc_r as the partial remainder; a zero
  // divisor always "fits", yielding all-ones quotient and remainder = A.
  assign rem_shift_s = {acc_r, md_a_r[31]};
  assign rem_diff_s  = rem_shift_s[31:0] - md_b_r;
  assign take_s      = rem_shift_s >= {1'b0, md_b_r};

  // Next values of the iteration registers
  always_comb begin
    md_a_next_s = md_a_r;
    md_b_next_s = md_b_r;
    acc_next_s  = acc_r;
    if (md_op_r == 3'd0) begin
      acc_next_s  = acc_r + (md_b_r[0] ? md_a_r : 32'h0);
      md_a_next_s = md_a_r << 1;
      md_b_next_s = md_b_r >> 1;
    end else begin
      acc_next_s  = take_s ? rem_diff_s : rem_shift_s[31:0];
      md_a_next_s = {md_a_r[30:0], take_s};
      md_b_next_s = md_b_r;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (issue_md_s && !stall_i) begin
          state_next_s = S_BUSY;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (count_r == 5'd0) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (!stall_i) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Multiply/divide operand latch and iteration registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_r <= 5'd0;
      md_op_r <= 3'd0;
      md_a_r  <= 32'h0;
      md_b_r  <= 32'h0;
      acc_r   <= 32'h0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (issue_md_s && !stall_i) begin
            count_r <= 5'd31;
            md_op_r <= op_s[2:0];
            md_a_r  <= opa_s;
            md_b_r  <= opb_s;
            acc_r   <= 32'h0;
          end
        end
        S_BUSY: begin
          md_a_r <= md_a_next_s;
          md_b_r <= md_b_next_s;
          acc_r  <= acc_next_s;
          if (count_r != 5'd0) begin
            count_r <= count_r - 5'd1;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Pipeline output registers: advance, insert a bubble, or hold
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ir_r        <= 64'h0;
      pc_r        <= 32'h0;
      reg_data1_r <= 32'h0;
      reg_data2_r <= 32'h0;
      sp_data_r   <= 32'h0;
      sp_write_r  <= 2'd0;
      result_r    <= 32'h0;
      pc_set_r    <= 1'b0;
      ccr_r       <= 4'h0;
    end else if (advance_s) begin
      ir_r        <= ir_i;
      pc_r        <= pc_i;
      reg_data1_r <= reg_data1_i;
      reg_data2_r <= reg_data2_i;
      sp_data_r   <= sp_data_i;
      sp_write_r  <= sp_write_i;
      result_r    <= result_s;
      pc_set_r    <= taken_s;
      if (type_s == T_ALU) begin
        ccr_r <= {alu_c_s, alu_res_s[31], alu_v_s, (alu_res_s == 32'h0)};
      end
    end else if (bubble_s) begin
      ir_r       <= 64'h0;
      sp_write_r <= 2'd0;
      result_r   <= 32'h0;
      pc_set_r   <= 1'b0;
    end
  end

  assign ir_o        = ir_r;
  assign pc_o        = pc_r;
  assign reg_data1_o = reg_data1_r;
  assign reg_data2_o = reg_data2_r;
  assign sp_data_o   = sp_data_r;
  assign sp_write_o  = sp_write_r;
  assign result_o    = result_r;
  assign pc_set_o    = pc_set_r;
  assign ccr_o       = ccr_r;

endmodule

// File: tb/tb_execute.sv
// Randomized self-checking bench for the execute stage against a transaction-level model.
module tb_execute;
  import bexkat1Def::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i, reg_data1_i, reg_data2_i, sp_data_i;
  logic [1:0]  sp_write_i;
  logic        stall_i;
  logic        stall_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o, reg_data1_o, reg_data2_o, sp_data_o, result_o;
  logic [1:0]  sp_write_o;
  logic        pc_set_o;
  logic [3:0]  ccr_o;

  int checks = 0;
  int errors = 0;
  logic [3:0]  ccr_m;
  logic [63:0] last_ir;
  logic [31:0] last_res;

  execute dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i),
    .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
    .sp_data_i(sp_data_i), .sp_write_i(sp_write_i), .stall_i(stall_i),
    .stall_o(stall_o), .ir_o(ir_o), .pc_o(pc_o),
    .reg_data1_o(reg_data1_o), .reg_data2_o(reg_data2_o),
    .sp_data_o(sp_data_o), .sp_write_o(sp_write_o),
    .result_o(result_o), .pc_set_o(pc_set_o), .ccr_o(ccr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] rand_single_type();
    logic [3:0] types [9] = '{T_ALU, T_ALU, T_ALU, T_LOAD, T_STORE, T_PUSH, T_POP, T_INH, T_BRANCH};
    return types[$urandom_range(0, 8)];
  endfunction

  // Reference semantics of a single-cycle instruction
  task automatic ref_single(input logic [3:0] ty, input logic [3:0] op, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [31:0] a, input logic [31:0] r2,
                            input logic [3:0] cin, output logic [31:0] res, output logic tk,
                            output logic [3:0] cout);
    logic [31:0] b;
    longint unsigned ures;
    longint sres;
    logic c, v;
    b = op[3] ? imm : r2;
    res = 32'h0; tk = 1'b0; cout = cin; c = 1'b0; v = 1'b0;
    case (ty)
      T_ALU: begin
        case (op[2:0])
          3'd0: begin
            ures = longint'(a) + longint'(b);
            res  = a + b;
            c    = ures > 64'hFFFF_FFFF;
            sres = longint'($signed(a)) + longint'($signed(b));
            v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
          end
          3'd1: begin
            res  = a - b;
            c    = a < b;
            sres = longint'($signed(a)) - longint'($signed(b));
            v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
          end
          3'd2: res = a & b;
          3'd3: res = a | b;
          3'd4: res = a ^ b;
          3'd5: res = a << b[4:0];
          3'd6: res = a >> b[4:0];
          default: res = $signed(a) >>> b[4:0];
        endcase
        cout = {c, res[31], v, (res == 32'h0)};
      end
      T_LOAD, T_STORE: res = r2 + imm;
      T_PUSH, T_INH:   res = imm;
      T_POP:           res = a;
      T_BRANCH: begin
        res = pc + imm;
        tk  = (op == 4'd0) || (op == 4'd1 && cin[0]) || (op == 4'd2 && !cin[0]) ||
              (op == 4'd3 && (cin[2] ^ cin[1])) || (op == 4'd4 && cin[3]);
      end
      default: res = 32'h0;
    endcase
  endtask

  task automatic run_single(input logic [3:0] ty, input logic [3:0] op, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [31:0] a, input logic [31:0] r2,
                            input bit stall_first);
    logic [63:0] ir;
    logic [31:0] res;
    logic tk;
    logic [3:0] cout;
    logic [1:0] spw;
    ir  = {imm, ty, op, 24'($urandom)};
    spw = 2'($urandom);
    ir_i = ir; pc_i = pc; reg_data1_i = a; reg_data2_i = r2;
    sp_data_i = $urandom; sp_write_i = spw;
    if (stall_first) begin
      stall_i = 1'b1;
      #1;
      check("stall_o_down", stall_o, 1'b1);
      tick();
      check("hold_ir", ir_o, last_ir);
      check("hold_res", result_o, last_res);
      check("hold_ccr", ccr_o, ccr_m);
    end
    stall_i = 1'b0;
    #1;
    check("stall_o_single", stall_o, 1'b0);
    ref_single(ty, op, imm, pc, a, r2, ccr_m, res, tk, cout);
    tick();
    check("ir_o", ir_o, ir);
    check("pc_o", pc_o, pc);
    check("reg_data1_o", reg_data1_o, a);
    check("sp_write_o", sp_write_o, spw);
    check("result_o", result_o, res);
    check("pc_set_o", pc_set_o, tk);
    check("ccr_o", ccr_o, cout);
    ccr_m = cout; last_ir = ir; last_res = res;
  endtask

  // Issue one MD op; pat[k] is stall_i in cycle k after issue (pat[0] must be 0)
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [39:0] pat);
    logic [63:0] ir;
    logic [31:0] exp;
    int rel;
    ir = {32'($urandom), T_MD, {1'b0, op}, 24'($urandom)};
    case (op)
      3'd0:    exp = a * b;
      3'd1:    exp = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: exp = (b == 32'h0) ? a : a % b;
    endcase
    rel = 33;
    while (pat[rel] && rel < 38) rel++;
    ir_i = ir; pc_i = $urandom; reg_data1_i = a; reg_data2_i = b;
    sp_data_i = $urandom; sp_write_i = 2'($urandom);
    for (int k = 0; k <= rel; k++) begin
      stall_i = pat[k];
      #1;
      check("md_stall_o", stall_o, (k <= 32) ? 1'b1 : pat[k]);
      tick();
      if (k < rel) begin
        check("md_bubble_ir", ir_o, 64'h0);
        check("md_bubble_res", result_o, 32'h0);
        check("md_bubble_pcset", pc_set_o, 1'b0);
      end else begin
        check("md_result", result_o, exp);
        check("md_ir", ir_o, ir);
        check("md_ccr", ccr_o, ccr_m);
      end
    end
    stall_i = 1'b0;
    last_ir = ir; last_res = exp;
  endtask

  initial begin
    logic [39:0] pat;
    logic [31:0] a, b;
    rst_i = 1'b0; stall_i = 1'b0;
    ir_i = 64'h0; pc_i = 32'h0; reg_data1_i = 32'h0; reg_data2_i = 32'h0;
    sp_data_i = 32'h0; sp_write_i = 2'd0;
    ccr_m = 4'h0; last_ir = 64'h0; last_res = 32'h0;

    // reset with random non-MD inputs
    for (int i = 0; i < 2; i++) begin
      ir_i = {32'($urandom), rand_single_type(), 28'($urandom)};
      pc_i = $urandom; reg_data1_i = $urandom; reg_data2_i = $urandom;
      sp_data_i = $urandom; sp_write_i = 2'($urandom); stall_i = 1'($urandom);
      #1;
      check("rst_stall_o", stall_o, stall_i);
      tick();
      check("rst_ir", ir_o, 64'h0);
      check("rst_pc", pc_o, 32'h0);
      check("rst_rd1", reg_data1_o, 32'h0);
      check("rst_rd2", reg_data2_o, 32'h0);
      check("rst_sp", sp_data_o, 32'h0);
      check("rst_spw", sp_write_o, 2'd0);
      check("rst_res", result_o, 32'h0);
      check("rst_pcset", pc_set_o, 1'b0);
      check("rst_ccr", ccr_o, 4'h0);
    end
    rst_i = 1'b1;

    run_single(T_ALU, 4'h8, 32'h1, 32'h40, 32'h7FFF_FFFF, $urandom, 1'b0);
    check("add_ovf_res", result_o, 32'h8000_0000);
    check("add_ovf_ccr", ccr_o, 4'b0110);
    run_single(T_ALU, 4'h1, $urandom, 32'h44, 32'h5, 32'h5, 1'b0);
    check("sub_zero_ccr", ccr_o, 4'b0001);
    run_single(T_BRANCH, 4'h1, 32'h20, 32'h100, $urandom, $urandom, 1'b0);
    check("beq_taken_res", result_o, 32'h120);
    check("beq_taken", pc_set_o, 1'b1);
    run_single(T_ALU, 4'h0, $urandom, 32'h48, 32'h1, 32'h1, 1'b0);
    run_single(T_BRANCH, 4'h1, 32'h20, 32'h100, $urandom, $urandom, 1'b0);
    check("beq_not_taken", pc_set_o, 1'b0);

    run_md(3'd1, 32'd100, 32'd7, 40'h0);
    check("divu_100_7", result_o, 32'd14);
    run_md(3'd2, 32'd100, 32'd7, 40'h0);
    check("modu_100_7", result_o, 32'd2);
    run_md(3'd1, 32'd9, 32'd0, 40'h0);
    check("divu_by_zero", result_o, 32'hFFFF_FFFF);
    run_md(3'd0, 32'h1_0000, 32'h1_0000, 40'h0);
    check("mul_wrap", result_o, 32'h0);
    pat = 40'h0; pat[10] = 1'b1; pat[33] = 1'b1;
    run_md(3'd1, 32'd1000, 32'd9, pat);
    check("divu_stalled", result_o, 32'd111);

    // random mix of single-cycle ops, downstream stalls and MD ops
    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 39) begin
        pat = 40'h0;
        for (int j = 1; j < 36; j++) pat[j] = ($urandom_range(0, 3) == 0);
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'h0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
        run_md(3'($urandom_range(0, 2)), a, b, pat);
        if (i % 80 == 79) run_md(3'($urandom_range(0, 2)), $urandom, $urandom, 40'h0);
      end else begin
        run_single(rand_single_type(), 4'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                   ($urandom_range(0, 7) == 0));
      end
    end

    // reset in the middle of a divide
    ir_i = {32'($urandom), T_MD, 4'h1, 24'($urandom)};
    reg_data1_i = 32'd500; reg_data2_i = 32'd3; stall_i = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    rst_i = 1'b0;
    tick();
    check("midrst_ir", ir_o, 64'h0);
    check("midrst_res", result_o, 32'h0);
    check("midrst_ccr", ccr_o, 4'h0);
    rst_i = 1'b1;
    ccr_m = 4'h0; last_ir = 64'h0; last_res = 32'h0;
    run_single(T_ALU, 4'h0, $urandom, 32'h200, 32'd20, 32'd22, 1'b0);
    check("after_rst_add", result_o, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
